// File: rtl/uart_rx_ctrl.sv
// UART command-frame parser: SOF(0x02), OP, LEN, payload, optional CHK -> held command.
// Define UART_RX_CTRL_CHKSUM_EN to require and verify the trailing XOR checksum byte.
module uart_rx_ctrl #(
  parameter int MAX_LEN       = 4,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b_tick,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        busy
);

  localparam int         TW  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0] SOF = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t        state_reg;
  logic [2:0]    idx_reg;
  logic [TW-1:0] tmo_reg;
  logic [3:0]    lane_sel;
  logic          parsing;
  logic          tmo_hit;
  logic          last_byte;
`ifdef UART_RX_CTRL_CHKSUM_EN
  logic [7:0]    xor_reg;
`endif

  assign busy    = (state_reg != S_IDLE);
  assign parsing = (state_reg == S_OPC) || (state_reg == S_LEN) ||
                   (state_reg == S_PAYLOAD) || (state_reg == S_CHK);
  // A byte arriving on the terminal tick cancels the timeout.
  assign tmo_hit = parsing && b_tick && !rx_done &&
                   (tmo_reg == TW'(TIMEOUT_TICKS - 1));
  assign last_byte = (idx_reg == (cmd_len - 3'd1));

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_sel[gi] = (idx_reg[1:0] == 2'(gi));
  end

`ifndef UART_RX_CTRL_CHKSUM_EN
  assign err_chk = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      tmo_reg     <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_RX_CTRL_CHKSUM_EN
      xor_reg     <= '0;
      err_chk     <= 1'b0;
`endif
    end else begin
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_RX_CTRL_CHKSUM_EN
      err_chk     <= 1'b0;
`endif

      if (!parsing || rx_done) begin
        tmo_reg <= '0;
      end else if (b_tick) begin
        tmo_reg <= tmo_reg + 1'b1;
      end

      if (tmo_hit) begin
        err_timeout <= 1'b1;
        tmo_reg     <= '0;
        state_reg   <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (rx_done && (rx_data == SOF)) begin
              state_reg <= S_OPC;
            end
          end

          S_OPC: begin
            if (rx_done) begin
              cmd_op    <= rx_data;
`ifdef UART_RX_CTRL_CHKSUM_EN
              xor_reg   <= rx_data;
`endif
              state_reg <= S_LEN;
            end
          end

          S_LEN: begin
            if (rx_done) begin
              if (rx_data > 8'(MAX_LEN)) begin
                err_len   <= 1'b1;
                state_reg <= S_IDLE;
              end else begin
                cmd_len     <= rx_data[2:0];
                cmd_payload <= '0;
                idx_reg     <= '0;
`ifdef UART_RX_CTRL_CHKSUM_EN
                xor_reg     <= xor_reg ^ rx_data;
                state_reg   <= (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
`else
                if (rx_data == 8'd0) begin
                  cmd_valid <= 1'b1;
                  state_reg <= S_HOLD;
                end else begin
                  state_reg <= S_PAYLOAD;
                end
`endif
              end
            end
          end

          S_PAYLOAD: begin
            if (rx_done) begin
              for (int i = 0; i < 4; i++) begin
                if (lane_sel[i]) begin
                  cmd_payload[8*i +: 8] <= rx_data;
                end
              end
              idx_reg <= idx_reg + 3'd1;
`ifdef UART_RX_CTRL_CHKSUM_EN
              xor_reg <= xor_reg ^ rx_data;
              if (last_byte) begin
                state_reg <= S_CHK;
              end
`else
              if (last_byte) begin
                cmd_valid <= 1'b1;
                state_reg <= S_HOLD;
              end
`endif
            end
          end

          S_CHK: begin
`ifdef UART_RX_CTRL_CHKSUM_EN
            if (rx_done) begin
              if (rx_data == xor_reg) begin
                cmd_valid <= 1'b1;
                state_reg <= S_HOLD;
              end else begin
                err_chk   <= 1'b1;
                state_reg <= S_IDLE;
              end
            end
`else
            state_reg <= S_IDLE;
`endif
          end

          S_HOLD: begin
            // Bytes landing while a command is held are lost, never parsed.
            if (rx_done) begin
              err_overrun <= 1'b1;
            end
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state_reg <= S_IDLE;
            end
          end

          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
